// File: rtl/cpu_mc_if.sv
// Instruction-fetch request/acknowledge bus between cpu_mc (master) and the instruction memory (slave).
interface cpu_mc_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle MIPS-subset CPU: FETCH/DECODE/EXEC/WB sequencer, 32-entry register file, ALU.
// Define CPU_MC_BRANCH_EN to make BEQ/BNE/J redirect the pc; otherwise they retire as NOPs.
module cpu_mc #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          XLEN     = 32
) (
   input  logic            clk_cpu,
   input  logic            reset,
   cpu_mc_if.master        imem,
   output logic            retire,
   output logic [XLEN-1:0] retire_pc,
   output logic            illegal,
   input  logic [4:0]      dbg_adrs,
   output logic [XLEN-1:0] dbg_data
);

   typedef enum logic [2:0] {
      ST_RST_WAIT,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_LUI
   } alu_op_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_alu;
   logic [XLEN-1:0] r_next_pc;
   logic            r_illegal;
   logic [XLEN-1:0] r_regs [32];

   logic            w_imem_req;
   logic            w_inst_ld;
   logic            w_dec_ld;
   logic            w_exec_ld;
   logic            w_wb;

   logic [5:0]      w_opcode;
   logic [5:0]      w_funct;
   logic [4:0]      w_rs;
   logic [4:0]      w_rt;
   logic [4:0]      w_rd;
   logic [15:0]     w_imm16;

   logic            w_legal;
   logic            w_writes;
   logic            w_zext;
   logic            w_use_imm;
   logic [4:0]      w_dest;
   alu_op_t         w_alu_op;

   logic [XLEN-1:0] w_opb;
   logic [XLEN-1:0] w_alu_res;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_next_pc;
   logic            w_rf_we;

   assign w_opcode = r_inst[31:26];
   assign w_rs     = r_inst[25:21];
   assign w_rt     = r_inst[20:16];
   assign w_rd     = r_inst[15:11];
   assign w_funct  = r_inst[5:0];
   assign w_imm16  = r_inst[15:0];

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         r_state <= ST_RST_WAIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_imem_req   = 1'b0;
      w_inst_ld    = 1'b0;
      w_dec_ld     = 1'b0;
      w_exec_ld    = 1'b0;
      w_wb         = 1'b0;
      case (r_state)
         ST_RST_WAIT: w_state_next = ST_FETCH;
         ST_FETCH: begin
            w_imem_req = 1'b1;
            if (imem.imem_ack) begin
               w_inst_ld    = 1'b1;
               w_state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            w_dec_ld     = 1'b1;
            w_state_next = ST_EXEC;
         end
         ST_EXEC: begin
            w_exec_ld    = 1'b1;
            w_state_next = ST_WB;
         end
         ST_WB: begin
            w_wb         = 1'b1;
            w_state_next = ST_FETCH;
         end
         default: w_state_next = ST_RST_WAIT;
      endcase
   end

   // Illegal encodings decode with w_writes=0 so they fall through as NOPs.
   always_comb begin
      w_legal   = 1'b1;
      w_writes  = 1'b0;
      w_zext    = 1'b0;
      w_use_imm = 1'b1;
      w_dest    = w_rt;
      w_alu_op  = ALU_ADD;
      case (w_opcode)
         6'h00: begin
            w_dest    = w_rd;
            w_use_imm = 1'b0;
            w_writes  = 1'b1;
            case (w_funct)
               6'h21:   w_alu_op = ALU_ADD;
               6'h23:   w_alu_op = ALU_SUB;
               6'h24:   w_alu_op = ALU_AND;
               6'h25:   w_alu_op = ALU_OR;
               6'h2A:   w_alu_op = ALU_SLT;
               default: begin
                  w_legal  = 1'b0;
                  w_writes = 1'b0;
               end
            endcase
         end
         6'h09: w_writes = 1'b1;
         6'h0D: begin
            w_writes = 1'b1;
            w_zext   = 1'b1;
            w_alu_op = ALU_OR;
         end
         6'h0F: begin
            w_writes = 1'b1;
            w_alu_op = ALU_LUI;
         end
         6'h02, 6'h04, 6'h05: w_writes = 1'b0;
         default: w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_opb     = w_use_imm ? r_imm : r_b;
      w_alu_res = '0;
      case (w_alu_op)
         ALU_ADD: w_alu_res = r_a + w_opb;
         ALU_SUB: w_alu_res = r_a - w_opb;
         ALU_AND: w_alu_res = r_a & w_opb;
         ALU_OR:  w_alu_res = r_a | w_opb;
         ALU_SLT: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_opb))};
         ALU_LUI: w_alu_res = {r_imm[15:0], 16'h0000};
         default: w_alu_res = '0;
      endcase
   end

   assign w_pc_plus4 = r_pc + 32'd4;

`ifdef CPU_MC_BRANCH_EN
   // r_imm is sign-extended for branch opcodes, so shifting it gives the byte offset.
   always_comb begin
      w_next_pc = w_pc_plus4;
      if (((w_opcode == 6'h04) && (r_a == r_b)) || ((w_opcode == 6'h05) && (r_a != r_b))) begin
         w_next_pc = w_pc_plus4 + {r_imm[XLEN-3:0], 2'b00};
      end else if (w_opcode == 6'h02) begin
         w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
      end
   end
`else
   assign w_next_pc = w_pc_plus4;
`endif

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_inst    <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_imm     <= '0;
         r_alu     <= '0;
         r_next_pc <= '0;
         r_illegal <= 1'b0;
      end else begin
         if (w_inst_ld) begin
            r_inst <= imem.imem_rdata;
         end
         if (w_dec_ld) begin
            r_a   <= r_regs[w_rs];
            r_b   <= r_regs[w_rt];
            r_imm <= w_zext ? {16'h0000, w_imm16} : {{16{w_imm16[15]}}, w_imm16};
         end
         if (w_exec_ld) begin
            r_alu     <= w_alu_res;
            r_next_pc <= w_next_pc;
         end
         if (w_wb) begin
            r_pc <= r_next_pc;
            if (!w_legal) begin
               r_illegal <= 1'b1;
            end
         end
      end
   end

   // Entry 0 is never written, so it reads as zero without a dedicated mux.
   assign w_rf_we = w_wb && w_writes && (w_dest != 5'd0);

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_rf_we) begin
         r_regs[w_dest] <= r_alu;
      end
   end

   assign imem.imem_req  = w_imem_req;
   assign imem.imem_addr = r_pc;
   assign retire         = w_wb;
   assign retire_pc      = w_wb ? r_pc : '0;
   assign illegal        = r_illegal;
   assign dbg_data       = r_regs[dbg_adrs];

endmodule

// File: tb/tb_cpu_mc.sv
// Randomized self-checking bench for cpu_mc against an instruction-level reference model.
module tb_cpu_mc;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clk_cpu  = 1'b0;
   logic        reset    = 1'b1;
   logic [4:0]  dbg_adrs = 5'd0;
   logic        retire;
   logic [31:0] retire_pc;
   logic        illegal;
   logic [31:0] dbg_data;

   cpu_mc_if #(.XLEN(32)) imem_bus ();

   cpu_mc #(
      .RESET_PC (RESET_PC),
      .XLEN     (32)
   ) dut (
      .clk_cpu   (clk_cpu),
      .reset     (reset),
      .imem      (imem_bus),
      .retire    (retire),
      .retire_pc (retire_pc),
      .illegal   (illegal),
      .dbg_adrs  (dbg_adrs),
      .dbg_data  (dbg_data)
   );

   always #5 clk_cpu = ~clk_cpu;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic        m_illegal;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_pc      = RESET_PC;
      m_illegal = 1'b0;
   endtask

   // Instruction-set semantics; returns the register worth inspecting afterwards.
   task automatic model_exec(input logic [31:0] inst, output logic [4:0] chk);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sx;
      logic [31:0] res;
      logic [31:0] pc4;
      logic [31:0] npc;
      bit          ok;
      bit          wr;
      op  = inst[31:26];
      fn  = inst[5:0];
      rs  = inst[25:21];
      rt  = inst[20:16];
      a   = m_regs[rs];
      b   = m_regs[rt];
      sx  = {{16{inst[15]}}, inst[15:0]};
      pc4 = m_pc + 32'd4;
      npc = pc4;
      res = 32'h0;
      ok  = 1'b1;
      wr  = 1'b0;
      dst = rt;
      case (op)
         6'h00: begin
            dst = inst[15:11];
            case (fn)
               6'h21: begin res = a + b; wr = 1'b1; end
               6'h23: begin res = a - b; wr = 1'b1; end
               6'h24: begin res = a & b; wr = 1'b1; end
               6'h25: begin res = a | b; wr = 1'b1; end
               6'h2A: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1'b1; end
               default: ok = 1'b0;
            endcase
         end
         6'h09: begin res = a + sx; wr = 1'b1; end
         6'h0D: begin res = a | {16'h0000, inst[15:0]}; wr = 1'b1; end
         6'h0F: begin res = {inst[15:0], 16'h0000}; wr = 1'b1; end
`ifdef CPU_MC_BRANCH_EN
         6'h04: if (a == b) npc = pc4 + (sx << 2);
         6'h05: if (a != b) npc = pc4 + (sx << 2);
         6'h02: npc = {pc4[31:28], inst[25:0], 2'b00};
`else
         6'h02, 6'h04, 6'h05: npc = pc4;
`endif
         default: ok = 1'b0;
      endcase
      if (!ok) m_illegal = 1'b1;
      if (wr && dst != 5'd0) m_regs[dst] = res;
      m_pc = npc;
      chk  = wr ? dst : 5'($urandom_range(0, 7));
   endtask

   task automatic rand_inst(input bit allow_ill, output logic [31:0] inst);
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      int          k;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      k   = allow_ill ? $urandom_range(0, 12) : $urandom_range(0, 10);
      case (k)
         0:  inst = enc_r(6'h21, rd, rs, rt);
         1:  inst = enc_r(6'h23, rd, rs, rt);
         2:  inst = enc_r(6'h24, rd, rs, rt);
         3:  inst = enc_r(6'h25, rd, rs, rt);
         4:  inst = enc_r(6'h2A, rd, rs, rt);
         5:  inst = enc_i(6'h09, rt, rs, imm);
         6:  inst = enc_i(6'h0D, rt, rs, imm);
         7:  inst = enc_i(6'h0F, rt, rs, imm);
         8:  inst = enc_i(6'h04, rt, rs, imm);
         9:  inst = enc_i(6'h05, rt, rs, imm);
         10: inst = {6'h02, 26'($urandom)};
         11: inst = enc_r(6'h08, rd, rs, rt);
         default: inst = enc_i(6'h3F, rt, rs, imm);
      endcase
   endtask

   // Starts on the FETCH negedge (or the RST_WAIT negedge when first=1), ends on the next FETCH negedge.
   task automatic run_inst(input logic [31:0] inst, input int delay, input bit first);
      logic [4:0]  dr;
      logic [31:0] ipc;
      imem_bus.imem_ack = 1'b0;
      if (first) begin
         check_val("rst_wait_req", imem_bus.imem_req, 32'd0);
         @(negedge clk_cpu);
      end
      ipc = m_pc;
      check_val("fetch_req", imem_bus.imem_req, 32'd1);
      check_val("fetch_addr", imem_bus.imem_addr, ipc);
      for (int d = 0; d < delay; d++) begin
         imem_bus.imem_rdata = $urandom;
         @(negedge clk_cpu);
         check_val("stall_req", imem_bus.imem_req, 32'd1);
         check_val("stall_addr", imem_bus.imem_addr, ipc);
         check_val("stall_retire", retire, 32'd0);
      end
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = inst;
      @(negedge clk_cpu);
      imem_bus.imem_ack   = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = $urandom;
      check_val("decode_req", imem_bus.imem_req, 32'd0);
      check_val("decode_retire", retire, 32'd0);
      @(negedge clk_cpu);
      check_val("exec_retire", retire, 32'd0);
      @(negedge clk_cpu);
      check_val("wb_retire", retire, 32'd1);
      check_val("retire_pc", retire_pc, ipc);
      model_exec(inst, dr);
      dbg_adrs = dr;
      @(negedge clk_cpu);
      imem_bus.imem_ack = 1'b0;
      check_val("post_retire", retire, 32'd0);
      check_val("dbg_reg", dbg_data, m_regs[dr]);
      check_val("illegal", illegal, 32'(m_illegal));
      $display("inst pc=%h word=%h wait=%0d reg%0d=%h next_pc=%h", ipc, inst, delay, dr, m_regs[dr], m_pc);
   endtask

   task automatic release_reset();
      @(posedge clk_cpu);
      #1 reset = 1'b0;
      @(negedge clk_cpu);
   endtask

   task automatic read_dbg(input logic [4:0] a, output logic [31:0] d);
      dbg_adrs = a;
      #1 d = dbg_data;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] inst;
      logic [31:0] d;
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'h0;
      model_reset();
      repeat (3) @(negedge clk_cpu);

      check_val("rst_req", imem_bus.imem_req, 32'd0);
      check_val("rst_retire", retire, 32'd0);
      check_val("rst_retire_pc", retire_pc, 32'd0);
      check_val("rst_illegal", illegal, 32'd0);
      check_val("rst_addr", imem_bus.imem_addr, RESET_PC);
      for (int i = 0; i < 32; i++) begin
         read_dbg(5'(i), d);
         check_val("rst_reg", d, 32'd0);
      end

      release_reset();
      run_inst(enc_i(6'h09, 5'd1, 5'd0, 16'd5), 0, 1'b1);
      read_dbg(5'd1, d);
      check_val("addiu_5", d, 32'd5);
      run_inst(enc_i(6'h09, 5'd1, 5'd0, 16'hFFFF), 0, 1'b0);
      run_inst(enc_r(6'h2A, 5'd3, 5'd1, 5'd0), 0, 1'b0);
      read_dbg(5'd3, d);
      check_val("slt_neg", d, 32'd1);
      run_inst(enc_i(6'h09, 5'd1, 5'd1, 16'd1), 0, 1'b0);
      read_dbg(5'd1, d);
      check_val("addiu_wrap", d, 32'd0);
      run_inst(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF), 0, 1'b0);
      run_inst({6'h02, 26'h0100000}, 0, 1'b0);
      run_inst(enc_i(6'h0F, 5'd2, 5'd0, 16'h1234), 0, 1'b0);
      run_inst(enc_i(6'h0D, 5'd2, 5'd2, 16'h5678), 0, 1'b0);
      read_dbg(5'd2, d);
      check_val("lui_ori", d, 32'h1234_5678);
      run_inst(enc_i(6'h09, 5'd0, 5'd0, 16'd7), 0, 1'b0);
      run_inst(enc_i(6'h09, 5'd4, 5'd0, 16'd3), 5, 1'b0);

      for (int n = 0; n < 120; n++) begin
         rand_inst(1'b0, inst);
         run_inst(inst, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0);
      end

      // Reset while stalled in FETCH: request must drop immediately.
      imem_bus.imem_ack = 1'b0;
      #1 reset = 1'b1;
      #1 check_val("rst_fetch_req", imem_bus.imem_req, 32'd0);
      model_reset();
      @(negedge clk_cpu);
      release_reset();
      run_inst(enc_i(6'h09, 5'd5, 5'd0, 16'd4), 0, 1'b1);

      // Reset in EXEC of ADDIU $5,$0,9: no write, no retire.
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = enc_i(6'h09, 5'd5, 5'd0, 16'd9);
      @(negedge clk_cpu);
      imem_bus.imem_ack = 1'b0;
      @(negedge clk_cpu);
      reset = 1'b1;
      #1 check_val("rst_exec_req", imem_bus.imem_req, 32'd0);
      check_val("rst_exec_retire", retire, 32'd0);
      model_reset();
      @(negedge clk_cpu);
      check_val("rst_exec_retire2", retire, 32'd0);
      read_dbg(5'd5, d);
      check_val("rst_exec_r5", d, 32'd0);
      release_reset();
      run_inst(enc_i(6'h09, 5'd6, 5'd0, 16'd1), 0, 1'b1);

      run_inst(enc_i(6'h3F, 5'd7, 5'd0, 16'd1), 0, 1'b0);
      check_val("illegal_set", illegal, 32'd1);
      for (int n = 0; n < 3; n++) begin
         rand_inst(1'b0, inst);
         run_inst(inst, 0, 1'b0);
         check_val("illegal_sticky", illegal, 32'd1);
      end

      for (int n = 0; n < 120; n++) begin
         rand_inst(1'b1, inst);
         run_inst(inst, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_mc.md
# cpu_mc

Parametrised multi-cycle successor to the single-cycle CPU top. It fetches instructions from an external instruction memory over a request/acknowledge handshake and sequences each instruction through a FETCH/DECODE/EXEC/WB state machine. It contains its own 32-entry register file and ALU, and supports a MIPS R/I/J subset with branches, writes to rd or rt, and illegal-opcode detection. It sits between the instruction memory and the debug/trace logic of the system.

## Interface
Parameters:
- RESET_PC, 32'h00400000, PC value loaded on reset.
- XLEN, 32, datapath width. Only 32 is legal; instruction fields are fixed MIPS positions.

Ports:
- clk_cpu  in  1  CPU clock.
- reset  in  1  reset, asynchronous, active-high; clock clk_cpu.
- imem_req  out  1  instruction fetch request, held until acknowledged.
- imem_addr  out  XLEN  fetch address, equals pc while imem_req=1.
- imem_ack  in  1  fetch acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_pc  out  XLEN  pc of the retiring instruction, valid while retire=1.
- illegal  out  1  sticky flag, set by any undecodable instruction.
- dbg_adrs  in  5  debug register-file read address.
- dbg_data  out  XLEN  combinational read of register dbg_adrs; $0 always reads 0.

## Operation
- States: RST_WAIT -> FETCH -> DECODE -> EXEC -> WB -> FETCH.
- RST_WAIT: entered on reset, lasts one cycle, then goes to FETCH.
- FETCH: imem_req=1, imem_addr=pc. Holds until imem_ack=1. On ack, latches imem_rdata into inst and moves to DECODE. No timeout.
- DECODE: reads rs and rt into the A and B registers and forms the immediate.
- EXEC: computes alu_out and, when branches are compiled in, the next pc.
- WB: writes the destination register, updates pc, pulses retire, and returns to FETCH.
- R-type (opcode 0) funct codes: ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, SLT 0x2A (signed compare). Destination is rd.
- I-type: ADDIU 0x09 (sign-extended imm), ORI 0x0D (zero-extended imm), LUI 0x0F (imm<<16). Destination is rt.
- Branch/jump: BEQ 0x04, BNE 0x05, J 0x02. These write no register. See Configuration.
- Arithmetic wraps modulo 2^32. No overflow traps.
- Writes to $0 are discarded.
- Unknown opcode, or unknown funct under opcode 0:
  - illegal is set and stays set until reset.
  - The instruction executes as a NOP (no write, pc+4) and still retires.
- Register contents after reset: all zero.

## Timing
- Reset values: pc=RESET_PC, state=RST_WAIT, imem_req=0, retire=0, retire_pc=0, illegal=0, all registers 0.
- First imem_req=1 appears in the first cycle after reset deassertion plus the RST_WAIT cycle.
- Ack in the first FETCH cycle gives 4 cycles per instruction (FETCH, DECODE, EXEC, WB). Each wait cycle on imem_ack adds one cycle.
- A write in WB is visible to the next instruction's DECODE read.
- dbg_data reflects a write from the cycle after WB.
- imem_addr and imem_req are stable throughout FETCH.
- imem_ack outside FETCH is ignored.
- Reset asserted mid-instruction:
  - All state clears immediately and asynchronously.
  - imem_req drops in the same cycle.
  - The partially executed instruction neither writes a register nor retires.
- pc wraps from 0xFFFFFFFC to 0x00000000 with no error.

## Configuration
- CPU_MC_BRANCH_EN defined:
  - BEQ/BNE: taken target = pc+4+(sext(imm)<<2).
  - J: target = {pc_plus4[31:28], inst[25:0], 2'b00}.
- CPU_MC_BRANCH_EN undefined: opcodes 0x02/0x04/0x05 are legal NOPs. pc+4, illegal is not set.

## Test plan
- Reset release, imem_ack tied 1, ADDIU $1,$0,5 at 0x00400000 -> retire at 4th cycle after RST_WAIT; retire_pc=0x00400000; dbg $1=5; next imem_addr=0x00400004.
- ADDIU $1,$0,-1 then ADDIU $1,$1,1 -> $1=0xFFFFFFFF, then 0x00000000 (wrap). SLT $3,$1,$0 with $1=-1 -> $3=1. LUI $2,0x1234 then ORI $2,$2,0x5678 -> $2=0x12345678.
- ADDIU $0,$0,7 -> dbg $0=0, retire pulses. Opcode 0x3F -> illegal=1, pc advances by 4, illegal stays 1 across 3 further instructions.
- imem_ack held low 5 cycles in FETCH -> imem_req=1 and imem_addr constant throughout; retire delayed by exactly 5 cycles.
- CPU_MC_BRANCH_EN: BEQ $0,$0,-1 at 0x00400010 -> next fetch 0x00400010. J 0x0100000 -> fetch 0x00400000. Without macro: same BEQ -> fetch 0x00400014, illegal=0.
- Reset asserted in EXEC of ADDIU $5,$0,9 -> imem_req=0 at once, $5=0, no retire, pc=RESET_PC after release.
